// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed, XOR-checksummed byte
// stream packed big-endian into 32-bit words, one write strobe per word.
module imem_loader #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR} state_t;

    state_t      state, state_nx;
    logic [7:0]  addr;
    logic [31:0] shift;
    logic [1:0]  bcnt;
    logic [6:0]  wcnt;
    logic [6:0]  nwords;
    logic [7:0]  csum;
    logic        xfer;
    logic        len_bad;
    logic        last_word;

    assign xfer      = rx_valid & rx_ready;
    assign len_bad   = (rx_data == 8'd0) || (rx_data > 8'(MEM_WORDS));
    assign last_word = (wcnt + 7'd1) == nwords;

    // Every output is a decode of state or a register, so nothing on the
    // input side can reach an output combinationally.
    assign rx_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    assign wr_en    = (state == WRITE);
    assign wr_addr  = addr;
    assign wr_data  = shift;
    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign cpu_hold = (state != DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = LEN;
            LEN:             if (xfer) state_nx = len_bad ? ERR : DATA;
            DATA:            if (xfer && bcnt == 2'd3) state_nx = WRITE;
            WRITE:           state_nx = last_word ? CSUM : DATA;
            CSUM:            if (xfer) state_nx = (rx_data == csum) ? DONE : ERR;
            default:         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr   <= 8'd0;
            shift  <= 32'd0;
            bcnt   <= 2'd0;
            wcnt   <= 7'd0;
            nwords <= 7'd0;
            csum   <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        addr  <= 8'd0;
                        shift <= 32'd0;
                        bcnt  <= 2'd0;
                        wcnt  <= 7'd0;
                        csum  <= 8'd0;
                    end
                end
                LEN: if (xfer) nwords <= rx_data[6:0];
                DATA: begin
                    if (xfer) begin
                        shift <= {shift[23:0], rx_data};
                        csum  <= csum ^ rx_data;
                        bcnt  <= bcnt + 2'd1;
                    end
                end
                // Address wraps past 0xFC on a full 64-word load; CSUM follows.
                WRITE: begin
                    addr <= addr + 8'd4;
                    wcnt <= wcnt + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against a stream-level
// reference model (expected writes, final status, unstalled latency).
module tb_imem_loader;
    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, wr_en, cpu_hold, done, error;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    imem_loader #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [39:0] obsq[$];
    logic [39:0] expq[$];
    logic [7:0]  stream[$];
    bit          exp_done, exp_err;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) if (wr_en) obsq.push_back({wr_addr, wr_data});

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {3'd0, rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error},
                 {3'd0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0});
    endtask

    // Reference: what a stream should produce, from the format rules alone.
    task automatic model();
        int n;
        logic [7:0]  cs;
        logic [31:0] word;
        expq.delete();
        exp_done = 0;
        exp_err  = 0;
        n = int'(stream[0]);
        if (n == 0 || n > MEM_WORDS) begin
            exp_err = 1;
            return;
        end
        cs = 8'd0;
        for (int w = 0; w < n; w++) begin
            word = 32'd0;
            for (int b = 0; b < 4; b++) begin
                word = {word[23:0], stream[1 + 4*w + b]};
                cs   = cs ^ stream[1 + 4*w + b];
            end
            expq.push_back({8'((4*w) % 256), word});
        end
        if (stream[1 + 4*n] == cs) exp_done = 1;
        else                       exp_err  = 1;
    endtask

    task automatic build(input int n, input bit corrupt);
        logic [7:0] cs, b;
        stream.delete();
        stream.push_back(8'(n));
        if (n == 0 || n > MEM_WORDS) return;
        cs = 8'd0;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            cs = cs ^ b;
        end
        stream.push_back(corrupt ? cs ^ 8'($urandom_range(1, 255)) : cs);
    endtask

    // Called and returns at a falling edge; holds the byte until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("rx_ready_timeout", {47'd0, rx_ready}, 48'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // mode 0: unstalled, 1: valid toggling, 2: random gaps
    task automatic run_load(input string tag, input int mode);
        int c0, gap;
        model();
        obsq.delete();
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < stream.size(); i++) begin
            gap = (mode == 1) ? ((i % 2 == 0) ? 1 : 0) :
                  (mode == 2) ? int'($urandom_range(0, 3)) : 0;
            send_byte(stream[i], gap);
        end
        chk({tag, "_status"}, {44'd0, rx_ready, cpu_hold, done, error},
                              {44'd0, 1'b0, !exp_done, exp_done, exp_err});
        if (mode == 0)
            chk({tag, "_latency"}, 48'(cyc - c0), 48'(stream.size() + expq.size() + 1));
        chk({tag, "_nwrites"}, 48'(obsq.size()), 48'(expq.size()));
        for (int i = 0; i < expq.size() && i < obsq.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), {8'd0, obsq[i]}, {8'd0, expq[i]});
    endtask

    task automatic directed_good();
        stream = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05, 8'hAE};
    endtask

    initial begin
        #2 reset = 1'b1;
        #1 chk_reset_vals("reset_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle_after_reset");

        directed_good();
        model();
        chk("model_word0", {8'd0, expq[0]}, {8'd0, 8'h00, 32'h8C010004});
        chk("model_word1", {8'd0, expq[1]}, {8'd0, 8'h04, 32'h20020005});
        run_load("good", 0);

        directed_good();
        stream[9] = 8'hAF;
        run_load("bad_csum", 0);

        stream = '{8'h00};
        run_load("len_zero", 0);
        stream = '{8'h41};
        run_load("len_41", 0);

        directed_good();
        run_load("stall_good", 1);

        // Reset in the middle of the first word
        directed_good();
        obsq.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(stream[i], 0);
        #2 reset = 1'b1;
        #1 chk_reset_vals("reset_midload");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_vals("idle_after_midload_reset");
        chk("midload_nwrites", 48'(obsq.size()), 48'd0);
        run_load("good_after_reset", 0);

        build(64, 0);
        run_load("full64", 0);
        build(MEM_WORDS + 1 + int'($urandom_range(0, 255 - MEM_WORDS - 1)), 0);
        run_load("rand_illegal", 2);
        for (int t = 0; t < 12; t++) begin
            build(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0));
            run_load($sformatf("rand%0d", t), (t % 2 == 0) ? 0 : 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
